imm_chunker: RTL and testbench

- Narrows a 16-bit constant into a sequence of 6-bit immediate chunks for the instruction emitter. This is the inverse of the decode-side immediate extension.
- Each chunk is tagged with an opcode: LOAD means sign-extend the chunk into the destination; SHOR means shift the destination left by 5 and OR in the chunk's low 5 bits.
- Sits between the constant source (assembler/loader path) and the instruction formatter.
- Valid/ready handshake on both sides.

---
 rtl/imm_chunker_if.sv | 21 ++
 rtl/imm_chunker.sv | 105 ++++++++++
 tb/tb_imm_chunker.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_chunker_if.sv
// Handshake bundle for imm_chunker: constant input channel and chunk output channel.
interface imm_chunker_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        imm_valid;
    logic        imm_ready;
    logic [5:0]  imm_out;
    logic        imm_op;
    logic        imm_last;

    modport master (
        output in_valid, in_data, imm_ready,
        input  in_ready, imm_valid, imm_out, imm_op, imm_last
    );

    modport slave (
        input  in_valid, in_data, imm_ready,
        output in_ready, imm_valid, imm_out, imm_op, imm_last
    );
endinterface

// File: rtl/imm_chunker.sv
// Splits a 16-bit constant into 1..3 LOAD/SHOR immediate chunks, MSB chunk first.
module imm_chunker #(
    parameter bit ALLOW_SHORT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_chunker_if.slave  bus,
    output logic          busy
);

    typedef enum logic {IDLE, EMIT} state_e;

    state_e      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  n_q, n_d;
    logic [1:0]  k_q, k_d;

    logic [1:0]  n_new;
    logic [1:0]  remain;
    logic [15:0] shifted;
    logic        fits6, fits11;
    logic        last, fire, accept;

    // Sign bits above the chunk must all agree for the short forms.
    assign fits6  = (&bus.in_data[15:5])  | ~(|bus.in_data[15:5]);
    assign fits11 = (&bus.in_data[15:10]) | ~(|bus.in_data[15:10]);

    always_comb begin
        n_new = 2'd3;
        if (ALLOW_SHORT) begin
            if (fits6) begin
                n_new = 2'd1;
            end else if (fits11) begin
                n_new = 2'd2;
            end
        end
    end

    assign busy   = (state_q == EMIT);
    assign last   = (k_q == n_q - 2'd1);
    assign remain = n_q - 2'd1 - k_q;

    always_comb begin
        shifted = data_q;
        unique case (remain)
            2'd1:    shifted = data_q >> 5;
            2'd2:    shifted = data_q >> 10;
            default: shifted = data_q;
        endcase
    end

    always_comb begin
        bus.imm_valid = busy;
        bus.imm_op    = busy && (k_q != 2'd0);
        bus.imm_last  = busy && last;
        bus.imm_out   = 6'd0;
        if (busy) begin
            bus.imm_out = (k_q == 2'd0) ? shifted[5:0]
                                        : {1'b0, shifted[4:0]};
        end
    end

    // Ready is granted while the final chunk drains so constants chain without gaps.
    assign fire         = busy && bus.imm_ready;
    assign bus.in_ready = !busy || (fire && last);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        n_d     = n_q;
        k_d     = k_q;
        priority case (1'b1)
            accept: begin
                state_d = EMIT;
                data_d  = bus.in_data;
                n_d     = n_new;
                k_d     = 2'd0;
            end
            fire && last: begin
                state_d = IDLE;
                k_d     = 2'd0;
            end
            fire: begin
                k_d = k_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= 16'd0;
            n_q     <= 2'd0;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            n_q     <= n_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: tb/tb_imm_chunker.sv
// Bench for imm_chunker: table vectors, corner sequences and random values,
// with a chunk scoreboard and a register-rebuild model.
module tb_imm_chunker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_chunker_if if0 ();
    imm_chunker_if if1 ();
    logic busy0, busy1;

    imm_chunker #(.ALLOW_SHORT(1'b1)) u_short (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave),
        .busy  (busy0)
    );

    imm_chunker #(.ALLOW_SHORT(1'b0)) u_full (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave),
        .busy  (busy1)
    );

    typedef struct packed {
        logic [5:0] val;
        logic       op;
        logic       last;
    } chunk_t;

    typedef struct {
        int          d;
        logic [15:0] v;
        int          n;
        logic [5:0]  c0;
        logic [5:0]  c1;
        logic [5:0]  c2;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    chunk_t      sb   [2][$];
    chunk_t      pend [2][$];
    logic [15:0] vq   [2][$];
    logic [15:0] pendv[2];
    logic [15:0] acc  [2];
    bit          took [2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    function automatic chunk_t mk(logic [5:0] v, logic op, logic lst);
        chunk_t c;
        c = {v, op, lst};
        return c;
    endfunction

    task automatic mon(int d, logic ov, logic orr, logic [5:0] o,
                       logic op, logic lst, logic iv, logic ir);
        chunk_t got, e;
        logic [15:0] want;
        if (!rst_n) return;
        if (iv && ir) begin
            took[d] = 1'b1;
            for (int i = 0; i < pend[d].size(); i++) sb[d].push_back(pend[d][i]);
            vq[d].push_back(pendv[d]);
        end
        if (ov && orr) begin
            got = {o, op, lst};
            if (sb[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra chunk dut%0d: got %0h expected none", d, got);
            end else begin
                e = sb[d].pop_front();
                chk($sformatf("chunk dut%0d", d), got, e);
            end
            if (op) acc[d] = {acc[d][10:0], o[4:0]};
            else    acc[d] = {{10{o[5]}}, o};
            if (lst && vq[d].size() != 0) begin
                want = vq[d].pop_front();
                chk($sformatf("rebuild dut%0d", d), acc[d], want);
            end
        end
    endtask

    task automatic cyc();
        took[0] = 1'b0;
        took[1] = 1'b0;
        @(negedge clk);
        mon(0, if0.imm_valid, if0.imm_ready, if0.imm_out, if0.imm_op,
            if0.imm_last, if0.in_valid, if0.in_ready);
        mon(1, if1.imm_valid, if1.imm_ready, if1.imm_out, if1.imm_op,
            if1.imm_last, if1.in_valid, if1.in_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(int d, logic [15:0] v, logic vld);
        if (d == 0) begin
            if0.in_data = v;
            if0.in_valid = vld;
        end else begin
            if1.in_data = v;
            if1.in_valid = vld;
        end
    endtask

    task automatic set_rdy(int d, logic r);
        if (d == 0) if0.imm_ready = r;
        else        if1.imm_ready = r;
    endtask

    function automatic logic vld_of(int d);
        return (d == 0) ? if0.imm_valid : if1.imm_valid;
    endfunction

    task automatic model_pend(int d, logic [15:0] v, bit sh);
        logic signed [15:0] s;
        int n;
        s = v;
        if (sh && s >= -32 && s <= 31)          n = 1;
        else if (sh && s >= -1024 && s <= 1023) n = 2;
        else                                    n = 3;
        pend[d].delete();
        pendv[d] = v;
        case (n)
            1: pend[d].push_back(mk(v[5:0], 1'b0, 1'b1));
            2: begin
                pend[d].push_back(mk(v[10:5], 1'b0, 1'b0));
                pend[d].push_back(mk({1'b0, v[4:0]}, 1'b1, 1'b1));
            end
            default: begin
                pend[d].push_back(mk(v[15:10], 1'b0, 1'b0));
                pend[d].push_back(mk({1'b0, v[9:5]}, 1'b1, 1'b0));
                pend[d].push_back(mk({1'b0, v[4:0]}, 1'b1, 1'b1));
            end
        endcase
    endtask

    task automatic table_pend(vec_t t);
        logic [5:0] c;
        pend[t.d].delete();
        pendv[t.d] = t.v;
        for (int k = 0; k < t.n; k++) begin
            c = (k == 0) ? t.c0 : (k == 1) ? t.c1 : t.c2;
            pend[t.d].push_back(mk(c, k != 0, k == t.n - 1));
        end
    endtask

    task automatic push_in(int d, logic [15:0] v);
        bit ok;
        ok = 1'b0;
        set_in(d, v, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (took[d]) begin
                ok = 1'b1;
                break;
            end
        end
        set_in(d, v, 1'b0);
        if (!ok) timeout($sformatf("accept dut%0d", d));
    endtask

    task automatic drain(int d, bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (sb[d].size() == 0 && !vld_of(d)) begin
                done = 1'b1;
                break;
            end
            if (rnd) set_rdy(d, 1'($urandom_range(0, 1)));
            cyc();
        end
        set_rdy(d, 1'b1);
        if (!done) timeout($sformatf("drain dut%0d", d));
    endtask

    vec_t vecs[$];
    logic [15:0] rv;

    initial begin
        set_in(0, 16'd0, 1'b0);
        set_in(1, 16'd0, 1'b0);
        set_rdy(0, 1'b1);
        set_rdy(1, 1'b1);
        acc[0] = '0;
        acc[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst imm_valid", if0.imm_valid, 0);
        chk("rst imm_out", if0.imm_out, 0);
        chk("rst imm_op", if0.imm_op, 0);
        chk("rst imm_last", if0.imm_last, 0);
        chk("rst busy", busy0, 0);
        chk("rst full valid", if1.imm_valid, 0);
        chk("rst full busy", busy1, 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready after rst", if0.in_ready, 1);

        vecs = '{
            '{0, 16'h001F, 1, 6'h1F, 6'h00, 6'h00},
            '{0, 16'hFFE0, 1, 6'h20, 6'h00, 6'h00},
            '{0, 16'h0020, 2, 6'h01, 6'h00, 6'h00},
            '{0, 16'hFC00, 2, 6'h20, 6'h00, 6'h00},
            '{0, 16'h1234, 3, 6'h04, 6'h11, 6'h14},
            '{0, 16'h8000, 3, 6'h20, 6'h00, 6'h00},
            '{0, 16'h7FFF, 3, 6'h1F, 6'h1F, 6'h1F},
            '{0, 16'd1023, 2, 6'h1F, 6'h1F, 6'h00},
            '{0, 16'd1024, 3, 6'h01, 6'h00, 6'h00},
            '{0, 16'hFFFF, 1, 6'h3F, 6'h00, 6'h00},
            '{1, 16'h0005, 3, 6'h00, 6'h00, 6'h05},
            '{1, 16'hFFFF, 3, 6'h3F, 6'h1F, 6'h1F},
            '{1, 16'h1234, 3, 6'h04, 6'h11, 6'h14}
        };
        foreach (vecs[i]) begin
            table_pend(vecs[i]);
            push_in(vecs[i].d, vecs[i].v);
            chk($sformatf("first valid %h", vecs[i].v), vld_of(vecs[i].d), 1);
            drain(vecs[i].d, 1'b0);
        end

        // Stall on chunk 1 of 0x1234.
        model_pend(0, 16'h1234, 1'b1);
        push_in(0, 16'h1234);
        cyc();
        set_rdy(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall valid", if0.imm_valid, 1);
            chk("stall out", if0.imm_out, 6'h11);
            chk("stall op", if0.imm_op, 1);
            chk("stall last", if0.imm_last, 0);
            chk("stall in_ready", if0.in_ready, 0);
            chk("stall busy", busy0, 1);
        end
        set_rdy(0, 1'b1);
        drain(0, 1'b0);

        // Back-to-back 0x1234 then 0x0005 with in_valid held high.
        model_pend(0, 16'h1234, 1'b1);
        set_in(0, 16'h1234, 1'b1);
        cyc();
        chk("b2b first accept", took[0], 1);
        model_pend(0, 16'h0005, 1'b1);
        set_in(0, 16'h0005, 1'b1);
        chk("b2b rdy c0", if0.in_ready, 0);
        cyc();
        chk("b2b rdy c1", if0.in_ready, 0);
        cyc();
        chk("b2b c2 out", if0.imm_out, 6'h14);
        chk("b2b rdy c2", if0.in_ready, 1);
        cyc();
        chk("b2b second accept", took[0], 1);
        set_in(0, 16'h0005, 1'b0);
        chk("b2b no gap valid", if0.imm_valid, 1);
        chk("b2b next out", if0.imm_out, 6'h05);
        chk("b2b next last", if0.imm_last, 1);
        chk("b2b next op", if0.imm_op, 0);
        cyc();
        chk("b2b idle valid", if0.imm_valid, 0);
        chk("b2b idle busy", busy0, 0);
        drain(0, 1'b0);

        // Reset during chunk 1 of 0x7FFF.
        model_pend(0, 16'h7FFF, 1'b1);
        push_in(0, 16'h7FFF);
        cyc();
        chk("mid c1 out", if0.imm_out, 6'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", if0.imm_valid, 0);
        chk("mid rst busy", busy0, 0);
        chk("mid rst out", if0.imm_out, 0);
        sb[0].delete();
        vq[0].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post rst valid", if0.imm_valid, 0);
            chk("post rst in_ready", if0.in_ready, 1);
        end

        for (int i = 0; i < 40; i++) begin
            rv = 16'($urandom);
            if (i % 4 == 1) rv = {{6{rv[15]}}, rv[9:0]};
            if (i % 4 == 2) rv = {{11{rv[15]}}, rv[4:0]};
            model_pend(i % 2, rv, (i % 2) == 0);
            push_in(i % 2, rv);
            drain(i % 2, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
